// File: rtl/ci_pkg.sv
// Shared definitions for the CI media-interface transmit path.
package ci_pkg;
  localparam int unsigned PKT_LEN      = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_t;
endpackage

// File: rtl/ci_mdo_fifo.sv
// Byte FIFO with a speculative write pointer and a commit pointer; the reader
// only ever consumes committed bytes, rewind discards the uncommitted tail.
module ci_mdo_fifo #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_sync,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_rewind,
  input  logic                     i_commit,
  input  logic                     i_rd_en,
  output logic [7:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_cm, r_rd;
  logic [AW:0] w_wr_base, w_wr_nxt;

  // A rewind and the first byte of the replacement packet share one cycle.
  assign w_wr_base = i_rewind ? r_cm : r_wr;
  assign w_wr_nxt  = w_wr_base + (AW+1)'(i_wr_en);

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[w_wr_base[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      r_wr <= '0;
      r_cm <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= w_wr_nxt;
      if (i_commit) r_cm <= w_wr_nxt;
      if (i_rd_en)  r_rd <= r_rd + 1'b1;
    end
  end

  assign o_rd_data = r_mem[r_rd[AW-1:0]];
  assign o_level   = r_wr - r_rd;
endmodule

// File: rtl/ci_mdo_transmitter.sv
// CI media-data-output transmitter: buffers whole 188-byte packets and drives them
// on MDO/MCLKO/MOVAL/MOSTRT. Define CI_MDO_GAP_EN for idle periods between packets.
module ci_mdo_transmitter
  import ci_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned GAP_TICKS  = 4
) (
  input  logic                        clk,
  input  logic                        rst_sync,
  input  logic                        enable,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  input  logic                        s_start,
  output logic                        s_ready,
  output logic [7:0]                  ci_mdo,
  output logic                        ci_mclko,
  output logic                        ci_moval,
  output logic                        ci_mostrt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 pkt_count,
  output logic [7:0]                  drop_count
);
  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = $clog2(PKT_LEN);
  localparam int unsigned PW = $clog2(FIFO_DEPTH / PKT_LEN + 2);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || FIFO_DEPTH < PKT_LEN || GAP_TICKS < 1) begin : g_bad_param
    $error("ci_mdo_transmitter: invalid parameter set");
  end

  logic          w_accept, w_idx0, w_wr, w_rewind, w_commit, w_unframed;
  logic [IW-1:0] r_idx;
  logic          r_unf, r_live;
  logic [7:0]    r_drop;
  logic [7:0]    w_rd_data;
  logic          w_rd;

  assign w_accept   = s_valid && s_ready;
  assign w_idx0     = (r_idx == '0);
  assign w_wr       = w_accept && (s_start || !w_idx0);
  assign w_rewind   = w_accept && s_start && !w_idx0;
  assign w_commit   = w_accept && !s_start && (r_idx == IW'(PKT_LEN - 1));
  assign w_unframed = w_accept && !s_start && w_idx0;

  ci_mdo_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_sync  (rst_sync),
    .i_wr_en   (w_wr),
    .i_wr_data (s_data),
    .i_rewind  (w_rewind),
    .i_commit  (w_commit),
    .i_rd_en   (w_rd),
    .o_rd_data (w_rd_data),
    .o_level   (fifo_level)
  );

  assign s_ready = r_live && (fifo_level != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));

  // A run of unframed bytes is a contiguous stretch of accepted unframed cycles.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      r_idx  <= '0;
      r_unf  <= 1'b0;
      r_drop <= '0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_unf  <= w_unframed;
      if (w_accept && s_start) r_idx <= IW'(1);
      else if (w_commit)       r_idx <= '0;
      else if (w_wr)           r_idx <= r_idx + 1'b1;
      if (((w_unframed && !r_unf) || w_rewind) && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
    end
  end

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_tick, r_mclko;

  assign w_tick    = (r_cnt == CW'(CLK_DIV - 1));
  assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      r_cnt   <= '0;
      r_mclko <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_mclko <= (w_cnt_nxt >= CW'(CLK_DIV / 2));
    end
  end

  tx_state_t     r_state;
  logic [IW-1:0] r_ridx;
  logic [PW-1:0] r_pkts;
  logic [7:0]    r_mdo;
  logic          r_moval, r_mostrt;
  logic [15:0]   r_pkt_cnt;
  logic          w_pkt_end, w_may_start, w_start, w_last_rd;

  // In SEND, r_ridx==0 marks the period right after the last byte.
  assign w_pkt_end = (r_state == SEND) && (r_ridx == '0);
`ifdef CI_MDO_GAP_EN
  localparam int unsigned GW = $clog2(GAP_TICKS + 1);
  logic [GW-1:0] r_gap;
  assign w_may_start = (r_state == IDLE) || ((r_state == GAP) && (r_gap == GW'(GAP_TICKS - 1)));
`else
  assign w_may_start = (r_state == IDLE) || w_pkt_end;
`endif
  assign w_start   = w_tick && w_may_start && enable && (r_pkts != '0);
  assign w_rd      = w_start || (w_tick && (r_state == SEND) && (r_ridx != '0));
  assign w_last_rd = w_tick && (r_state == SEND) && (r_ridx == IW'(PKT_LEN - 1));

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      r_pkts <= '0;
    end else if (w_commit && !w_last_rd) begin
      r_pkts <= r_pkts + 1'b1;
    end else if (w_last_rd && !w_commit) begin
      r_pkts <= r_pkts - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      r_state   <= IDLE;
      r_ridx    <= '0;
      r_mdo     <= '0;
      r_moval   <= 1'b0;
      r_mostrt  <= 1'b0;
      r_pkt_cnt <= '0;
`ifdef CI_MDO_GAP_EN
      r_gap     <= '0;
`endif
    end else if (w_tick) begin
      if (w_pkt_end) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_start) begin
        r_mdo    <= w_rd_data;
        r_moval  <= 1'b1;
        r_mostrt <= 1'b1;
        r_ridx   <= IW'(1);
        r_state  <= SEND;
      end else begin
        case (r_state)
          SEND: begin
            r_mostrt <= 1'b0;
            if (r_ridx != '0) begin
              r_mdo  <= w_rd_data;
              r_ridx <= (r_ridx == IW'(PKT_LEN - 1)) ? '0 : r_ridx + 1'b1;
            end else begin
              r_moval <= 1'b0;
`ifdef CI_MDO_GAP_EN
              r_gap   <= '0;
              r_state <= GAP;
`else
              r_state <= IDLE;
`endif
            end
          end
`ifdef CI_MDO_GAP_EN
          GAP: begin
            r_moval <= 1'b0;
            if (r_gap == GW'(GAP_TICKS - 1)) r_state <= IDLE;
            else                             r_gap   <= r_gap + 1'b1;
          end
`endif
          default: begin
            r_moval  <= 1'b0;
            r_mostrt <= 1'b0;
            r_state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign ci_mdo     = r_mdo;
  assign ci_mclko   = r_mclko;
  assign ci_moval   = r_moval;
  assign ci_mostrt  = r_mostrt;
  assign pkt_count  = r_pkt_cnt;
  assign drop_count = r_drop;
endmodule

// File: tb/tb_ci_mdo_transmitter.sv
// Bench for ci_mdo_transmitter: framing table, scoreboard on MCLKO rising edges,
// plus enable-hold, mid-packet reset and commit-latency sequences.
module tb_ci_mdo_transmitter;
  import ci_pkg::*;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 256;
  localparam int unsigned GAP_TICKS  = 4;

  logic        clk = 1'b0;
  logic        rst_sync = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_start = 1'b0;
  logic        s_ready;
  logic [7:0]  ci_mdo;
  logic        ci_mclko, ci_moval, ci_mostrt;
  logic [8:0]  fifo_level;
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  ci_mdo_transmitter #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_TICKS  (GAP_TICKS)
  ) dut (
    .clk        (clk),
    .rst_sync   (rst_sync),
    .enable     (enable),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_start    (s_start),
    .s_ready    (s_ready),
    .ci_mdo     (ci_mdo),
    .ci_mclko   (ci_mclko),
    .ci_moval   (ci_moval),
    .ci_mostrt  (ci_mostrt),
    .fifo_level (fifo_level),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       st;
    logic [7:0] d;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int unf;
    int abort_at;
    int npkts;
    int exp_drop;
    int exp_pkts;
    int exp_run;
  } vec_t;
  vec_t tv [5];

  function automatic int run_len(input int n);
`ifdef CI_MDO_GAP_EN
    return (n > 0) ? int'(PKT_LEN) : 0;
`else
    return n * int'(PKT_LEN);
`endif
  endfunction

  // CAM-side model: sample on each MCLKO rising edge, pop the scoreboard.
  int   nbytes = 0, run = 0, last_run = 0, low = 0, last_low = 0;
  logic prev_mclk = 1'b0;
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (!rst_sync) begin
      prev_mclk = 1'b0;
      run = 0;
      low = 0;
    end else begin
      if (ci_mclko && !prev_mclk) begin
        if (ci_moval) begin
          if (low > 0) begin
            last_low = low;
            low = 0;
          end
          run++;
          nbytes++;
          if (q.size() == 0) begin
            chk("unexpected_byte", int'(ci_mdo), -1);
          end else begin
            mon_e = q.pop_front();
            chk("mdo", int'(ci_mdo), int'(mon_e.d));
            chk("mostrt", int'(ci_mostrt), int'(mon_e.st));
          end
        end else begin
          if (run > 0) begin
            last_run = run;
            run = 0;
          end
          low++;
        end
      end
      prev_mclk = ci_mclko;
    end
  end

  task automatic put(input logic [7:0] d, input logic st);
    int n;
    n = 0;
    s_data  = d;
    s_start = st;
    s_valid = 1'b1;
    while (!s_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("s_ready_wait", 0, 1);
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] seed, input int len, input bit push);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = (b == 0) ? TS_SYNC_BYTE : 8'(int'(seed) + b - 1);
      if (push) q.push_back('{st: (b == 0), d: d});
      put(d, b == 0);
    end
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic wait_pkts(input int target);
    int n;
    n = 0;
    while (int'(pkt_count) != target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_count", int'(pkt_count), target);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int drop_exp = 0;
  int pkt_exp  = 0;
  int base_n   = 0;
  int wn       = 0;
  int lat      = 0;

  initial begin
    tv[0] = '{0,   0, 1, 0, 1, run_len(1)};
    tv[1] = '{0, 100, 1, 1, 1, run_len(1)};
    tv[2] = '{5,   0, 0, 1, 0, 0};
    tv[3] = '{0,   0, 3, 0, 3, run_len(3)};
    tv[4] = '{3,  60, 2, 2, 2, run_len(2)};

    repeat (3) @(negedge clk);
    chk("rst_s_ready",  int'(s_ready), 0);
    chk("rst_mdo",      int'(ci_mdo), 0);
    chk("rst_mclko",    int'(ci_mclko), 0);
    chk("rst_moval",    int'(ci_moval), 0);
    chk("rst_level",    int'(fifo_level), 0);
    chk("rst_pkt_cnt",  int'(pkt_count), 0);
    chk("rst_drop_cnt", int'(drop_count), 0);
    rst_sync = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(s_ready), 1);

    for (int i = 0; i < 5; i++) begin
      last_run = 0;
      for (int k = 0; k < tv[i].unf; k++) put(8'(8'hC0 + k), 1'b0);
      if (tv[i].abort_at > 0) send_pkt(8'h80, tv[i].abort_at, 1'b0);
      for (int p = 0; p < tv[i].npkts; p++) send_pkt(8'(i * 40 + p * 7), int'(PKT_LEN), 1'b1);
      idle_inputs();
      drop_exp += tv[i].exp_drop;
      pkt_exp  += tv[i].exp_pkts;
      wait_pkts(pkt_exp);
      repeat (2 * CLK_DIV) @(negedge clk);
      chk("drop_count", int'(drop_count), drop_exp);
      chk("fifo_level", int'(fifo_level), 0);
      chk("queue_empty", q.size(), 0);
      if (tv[i].npkts > 0) chk("moval_run", last_run, tv[i].exp_run);
`ifdef CI_MDO_GAP_EN
      if (i == 3) chk("gap_periods", last_low, int'(GAP_TICKS));
`endif
    end

    base_n = nbytes;
    fork
      begin
        send_pkt(8'h10, int'(PKT_LEN), 1'b1);
        send_pkt(8'h20, int'(PKT_LEN), 1'b1);
        send_pkt(8'h30, int'(PKT_LEN), 1'b1);
        idle_inputs();
      end
      begin
        wn = 0;
        while (nbytes < base_n + int'(PKT_LEN) + 50 && wn < 10000) begin
          @(negedge clk);
          wn++;
        end
        chk("enable_drop_point", int'(nbytes >= base_n + int'(PKT_LEN) + 50), 1);
        enable = 1'b0;
      end
    join
    pkt_exp += 2;
    wait_pkts(pkt_exp);
    repeat (400) @(negedge clk);
    chk("held_pkt_count", int'(pkt_count), pkt_exp);
    chk("held_moval", int'(ci_moval), 0);
    chk("held_level", int'(fifo_level), int'(PKT_LEN));
    chk("held_queue", q.size(), int'(PKT_LEN));
    enable = 1'b1;
    pkt_exp += 1;
    wait_pkts(pkt_exp);
    repeat (2 * CLK_DIV) @(negedge clk);
    chk("released_queue", q.size(), 0);
    chk("released_level", int'(fifo_level), 0);

    base_n = nbytes;
    send_pkt(8'h55, int'(PKT_LEN), 1'b1);
    idle_inputs();
    wn = 0;
    while (nbytes < base_n + 20 && wn < 5000) begin
      @(negedge clk);
      wn++;
    end
    chk("mid_send_reached", int'(nbytes >= base_n + 20), 1);
    @(negedge clk);
    #2 rst_sync = 1'b0;
    #1;
    chk("arst_mdo",      int'(ci_mdo), 0);
    chk("arst_mclko",    int'(ci_mclko), 0);
    chk("arst_moval",    int'(ci_moval), 0);
    chk("arst_mostrt",   int'(ci_mostrt), 0);
    chk("arst_level",    int'(fifo_level), 0);
    chk("arst_pkt_cnt",  int'(pkt_count), 0);
    chk("arst_drop_cnt", int'(drop_count), 0);
    chk("arst_s_ready",  int'(s_ready), 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_sync = 1'b1;
    pkt_exp  = 0;
    drop_exp = 0;
    @(negedge clk);

    send_pkt(8'h66, int'(PKT_LEN), 1'b1);
    idle_inputs();
    lat = 0;
    while (!ci_mostrt && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("commit_latency_ok", int'(lat >= 1 && lat <= int'(CLK_DIV) + 1), 1);
    pkt_exp = 1;
    wait_pkts(pkt_exp);
    repeat (2 * CLK_DIV) @(negedge clk);
    chk("post_rst_drop", int'(drop_count), 0);
    chk("post_rst_level", int'(fifo_level), 0);
    chk("post_rst_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
